// File: rtl/letter_seq_if.sv
// Handshake/bus bundle between the letter sequence builder and its user.
// The builder takes the slave side; the controlling logic takes the master side.
interface letter_seq_if #(
  parameter int SEQ_LEN = 4
);
  localparam int IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

  logic                   start;
  logic [4:0]             letter_in;
  logic                   busy;
  logic                   show_valid;
  logic [4:0]             show_letter;
  logic [IDX_W-1:0]       show_idx;
  logic                   seq_valid;
  logic [5*SEQ_LEN-1:0]   seq_out;

  modport master (
    output start, letter_in,
    input  busy, show_valid, show_letter, show_idx, seq_valid, seq_out
  );

  modport slave (
    input  start, letter_in,
    output busy, show_valid, show_letter, show_idx, seq_valid, seq_out
  );
endinterface

// File: rtl/letter_seq_builder.sv
// Builds a SEQ_LEN-letter target sequence from the random letter stream, shows
// it one letter at a time, then holds it for the compare logic until restarted.
module letter_seq_builder #(
  parameter int SEQ_LEN     = 4,
  parameter int SAMPLE_GAP  = 8,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic         clk,
  input  logic         rst_n,
  letter_seq_if.slave  seq_if
);

  localparam int IDX_W  = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int CNT_W  = $clog2(SEQ_LEN + 1);
  localparam int GAP_W  = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int BUF_W  = 5 * SEQ_LEN;

  localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(SAMPLE_GAP - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SEQ_LEN - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(SEQ_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SHOW    = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [4:0]         last_q, last_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic               busy_q, busy_d;
  logic               show_valid_q, show_valid_d;
  logic [4:0]         show_letter_q, show_letter_d;
  logic [IDX_W-1:0]   show_idx_q, show_idx_d;
  logic               seq_valid_q, seq_valid_d;

  logic               sample_s, accept_s, cap_done_s, slot_end_s, show_done_s;

  // Valid letter codes are 0..14 with bit 4 clear.
  function automatic logic letter_ok(input logic [4:0] l);
    return (l[4] == 1'b0) && (l[3:0] != 4'd15);
  endfunction

  assign sample_s    = (state_q == ST_CAPTURE) && (gap_q == GAP_MAX);
  assign accept_s    = sample_s && letter_ok(seq_if.letter_in) &&
                       ((cnt_q == {CNT_W{1'b0}}) || (seq_if.letter_in != last_q));
  assign cap_done_s  = accept_s && (cnt_q == CNT_LAST);
  assign slot_end_s  = (state_q == ST_SHOW) && (hold_q == HOLD_MAX);
  assign show_done_s = slot_end_s && (idx_q == IDX_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start only matters in IDLE and DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    state_d = seq_if.start ? ST_CAPTURE : ST_IDLE;
      ST_CAPTURE: state_d = cap_done_s   ? ST_SHOW    : ST_CAPTURE;
      ST_SHOW:    state_d = show_done_s  ? ST_DONE    : ST_SHOW;
      ST_DONE:    state_d = seq_if.start ? ST_CAPTURE : ST_DONE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values; outputs are derived from next state so they register in step.
  always_comb begin
    gap_d  = gap_q;
    cnt_d  = cnt_q;
    buf_d  = buf_q;
    last_d = last_q;
    hold_d = hold_q;
    idx_d  = idx_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (seq_if.start) begin
          gap_d  = {GAP_W{1'b0}};
          cnt_d  = {CNT_W{1'b0}};
          buf_d  = {BUF_W{1'b0}};
          last_d = 5'd0;
          hold_d = {HOLD_W{1'b0}};
          idx_d  = {IDX_W{1'b0}};
        end else begin
          gap_d  = gap_q;
        end
      end
      ST_CAPTURE: begin
        gap_d = (gap_q == GAP_MAX) ? {GAP_W{1'b0}} : gap_q + 1'b1;
        if (accept_s) begin
          cnt_d  = cnt_q + 1'b1;
          last_d = seq_if.letter_in;
          for (int k = 0; k < SEQ_LEN; k++) begin
            buf_d[5*k +: 5] = (cnt_q == CNT_W'(k)) ? seq_if.letter_in : buf_q[5*k +: 5];
          end
        end else begin
          cnt_d = cnt_q;
        end
        hold_d = {HOLD_W{1'b0}};
        idx_d  = {IDX_W{1'b0}};
      end
      ST_SHOW: begin
        if (slot_end_s) begin
          hold_d = {HOLD_W{1'b0}};
          idx_d  = show_done_s ? {IDX_W{1'b0}} : idx_q + 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        gap_d  = {GAP_W{1'b0}};
        cnt_d  = {CNT_W{1'b0}};
        buf_d  = {BUF_W{1'b0}};
        last_d = 5'd0;
        hold_d = {HOLD_W{1'b0}};
        idx_d  = {IDX_W{1'b0}};
      end
    endcase

    busy_d        = (state_d == ST_CAPTURE) || (state_d == ST_SHOW);
    show_valid_d  = (state_d == ST_SHOW);
    seq_valid_d   = (state_d == ST_DONE);
    show_idx_d    = show_valid_d ? idx_d : {IDX_W{1'b0}};
    show_letter_d = 5'd0;
    for (int k = 0; k < SEQ_LEN; k++) begin
      show_letter_d = (show_valid_d && (idx_d == IDX_W'(k))) ? buf_d[5*k +: 5] : show_letter_d;
    end
  end

  // Counters, sequence buffer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q         <= {GAP_W{1'b0}};
      cnt_q         <= {CNT_W{1'b0}};
      buf_q         <= {BUF_W{1'b0}};
      last_q        <= 5'd0;
      hold_q        <= {HOLD_W{1'b0}};
      idx_q         <= {IDX_W{1'b0}};
      busy_q        <= 1'b0;
      show_valid_q  <= 1'b0;
      show_letter_q <= 5'd0;
      show_idx_q    <= {IDX_W{1'b0}};
      seq_valid_q   <= 1'b0;
    end else begin
      gap_q         <= gap_d;
      cnt_q         <= cnt_d;
      buf_q         <= buf_d;
      last_q        <= last_d;
      hold_q        <= hold_d;
      idx_q         <= idx_d;
      busy_q        <= busy_d;
      show_valid_q  <= show_valid_d;
      show_letter_q <= show_letter_d;
      show_idx_q    <= show_idx_d;
      seq_valid_q   <= seq_valid_d;
    end
  end

  assign seq_if.busy        = busy_q;
  assign seq_if.show_valid  = show_valid_q;
  assign seq_if.show_letter = show_letter_q;
  assign seq_if.show_idx    = show_idx_q;
  assign seq_if.seq_valid   = seq_valid_q;
  assign seq_if.seq_out     = buf_q;

endmodule

// File: tb/tb_letter_seq_builder.sv
// Directed bench for letter_seq_builder: a (4,3,5) instance for the main flow
// and a (2,1,1) instance for back-to-back sequences with start held high.
module tb_letter_seq_builder;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  letter_seq_if #(.SEQ_LEN(4)) if_a ();
  letter_seq_if #(.SEQ_LEN(2)) if_b ();

  letter_seq_builder #(.SEQ_LEN(4), .SAMPLE_GAP(3), .HOLD_CYCLES(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .seq_if(if_a)
  );
  letter_seq_builder #(.SEQ_LEN(2), .SAMPLE_GAP(1), .HOLD_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .seq_if(if_b)
  );

  always #5 clk = ~clk;

  logic [4:0] v1 [8];
  logic [4:0] v2 [8];
  logic [4:0] v3 [8];
  logic [4:0] v4 [8];
  logic [4:0] l1 [4];
  logic [4:0] l2 [4];
  logic [4:0] l3 [4];
  logic [4:0] pa [3];
  logic [4:0] pb [3];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs_a();
    return {2'b00, if_a.busy, if_a.show_valid, if_a.show_letter, if_a.show_idx,
            if_a.seq_valid, if_a.seq_out};
  endfunction

  function automatic logic [31:0] exp_a(input logic b, input logic sv, input logic [4:0] l,
                                        input logic [1:0] i, input logic q, input logic [19:0] s);
    return {2'b00, b, sv, l, i, q, s};
  endfunction

  function automatic logic [31:0] obs_b();
    return {13'd0, if_b.busy, if_b.show_valid, if_b.show_letter, if_b.show_idx,
            if_b.seq_valid, if_b.seq_out};
  endfunction

  function automatic logic [31:0] exp_b(input logic b, input logic sv, input logic [4:0] l,
                                        input logic i, input logic q, input logic [9:0] s);
    return {13'd0, b, sv, l, i, q, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle start from IDLE/DONE; next cycle must be CAPTURE with a cleared buffer.
  task automatic start_a();
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    @(negedge clk);
    check_eq("start_a", obs_a(), exp_a(1'b1, 1'b0, 5'd0, 2'd0, 1'b0, 20'd0));
  endtask

  task automatic capture_a(input logic [4:0] vals [8], input int n, input int pulse_at);
    for (int e = 0; e < 3 * n; e++) begin
      if_a.letter_in = vals[e / 3];
      if_a.start     = (e == pulse_at);
      if (e == 3 * n - 1) begin
        @(negedge clk);
        check_eq("cap_end_a", {30'd0, if_a.busy, if_a.show_valid}, {30'd0, 2'b10});
      end
      tick();
    end
    if_a.start = 1'b0;
  endtask

  task automatic show_a(input logic [4:0] l [4], input logic [19:0] seq, input int pulse_at);
    for (int c = 0; c < 20; c++) begin
      if_a.start = (c == pulse_at);
      @(negedge clk);
      check_eq("show_a", obs_a(), exp_a(1'b1, 1'b1, l[c / 5], 2'(c / 5), 1'b0, seq));
      tick();
    end
    if_a.start = 1'b0;
    @(negedge clk);
    check_eq("done_a", obs_a(), exp_a(1'b0, 1'b0, 5'd0, 2'd0, 1'b1, seq));
  endtask

  initial begin
    v1 = '{5'd3, 5'd5, 5'd9, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0};
    l1 = '{5'd3, 5'd5, 5'd9, 5'd2};
    v2 = '{5'd15, 5'd4, 5'd4, 5'd20, 5'd6, 5'd1, 5'd8, 5'd0};
    l2 = '{5'd4, 5'd6, 5'd1, 5'd8};
    v3 = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0};
    l3 = '{5'd1, 5'd2, 5'd3, 5'd4};
    v4 = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd0, 5'd0, 5'd0, 5'd0};
    pa = '{5'd1, 5'd14, 5'd7};
    pb = '{5'd2, 5'd0, 5'd9};

    rst_n = 1'b0;
    if_a.start = 1'b0; if_a.letter_in = 5'd7;
    if_b.start = 1'b0; if_b.letter_in = 5'd7;
    #12;
    check_eq("rst_a", obs_a(), 32'd0);
    check_eq("rst_b", obs_b(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      @(negedge clk);
      check_eq("idle_a", obs_a(), 32'd0);
    end

    // Basic capture 3,5,9,2.
    start_a();
    capture_a(v1, 4, -1);
    show_a(l1, 20'h124A3, -1);

    // Invalid codes and the adjacent repeat are dropped.
    start_a();
    capture_a(v2, 7, -1);
    show_a(l2, 20'h404C4, -1);

    // Stray start pulses during CAPTURE and SHOW.
    start_a();
    capture_a(v3, 4, 4);
    show_a(l3, 20'h20C41, 7);

    // Async reset in the middle of SHOW.
    start_a();
    capture_a(v4, 4, -1);
    repeat (8) tick();
    @(negedge clk);
    check_eq("mid_show_a", obs_a(), exp_a(1'b1, 1'b1, 5'd11, 2'd1, 1'b0, 20'h6B16A));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_a", obs_a(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      @(negedge clk);
      check_eq("post_rst_a", obs_a(), 32'd0);
    end

    // Back-to-back sequences with start held high on the small instance.
    if_b.start = 1'b1;
    tick();
    for (int it = 0; it < 3; it++) begin
      for (int c = 0; c < 5; c++) begin
        if_b.letter_in = (c == 0) ? pa[it] : ((c == 1) ? pb[it] : 5'd31);
        if (it == 2 && c == 4) if_b.start = 1'b0;
        @(negedge clk);
        case (c)
          0: check_eq("b_cap0", obs_b(), exp_b(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 10'd0));
          1: check_eq("b_cap1", obs_b(), exp_b(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, {5'd0, pa[it]}));
          2: check_eq("b_show0", obs_b(), exp_b(1'b1, 1'b1, pa[it], 1'b0, 1'b0, {pb[it], pa[it]}));
          3: check_eq("b_show1", obs_b(), exp_b(1'b1, 1'b1, pb[it], 1'b1, 1'b0, {pb[it], pa[it]}));
          default: check_eq("b_done", obs_b(), exp_b(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, {pb[it], pa[it]}));
        endcase
        tick();
      end
    end
    @(negedge clk);
    check_eq("b_done_hold", obs_b(), exp_b(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, {pb[2], pa[2]}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
